dst_serializer: RTL and testbench

- Downstream stage of the compressor input shift-register wrapper.
- Waits a programmable settle time after a start request, then captures the compressor's WIDTH-bit result vector (dst0..dstN concatenated, dst0 = LSB).
- Shifts the captured result out LSB-first over a 1-bit valid/ready stream.
- Keeps a running 32-bit signature (modular sum) of all captured results, so a bench or board can check results with few pins.

---
 rtl/dst_serializer.sv | 142 ++++++++++++++
 tb/tb_dst_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_serializer.sv
// dst_serializer: waits a settle time after start, captures the compressor
// result vector, shifts it out LSB-first over a 1-bit valid/ready stream and
// keeps a running 32-bit modular sum of every captured result.
module dst_serializer #(
  parameter int WIDTH  = 21,
  parameter int SETTLE = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dst,
  input  logic             start,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy,
  output logic [31:0]      signature,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  // The settle counter starts at SETTLE and capture happens on the edge that
  // sees it at zero, so capture lands SETTLE+1 edges after start is sampled
  // and a zero settle time still spends exactly one cycle in ST_SETTLE.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_sout;
  logic               r_sout_valid;
  logic               r_sout_last;
  logic               r_busy;
  logic [31:0]        r_signature;
  logic [15:0]        r_frame_count;

  logic [WIDTH-1:0]   w_shift_next;
  logic               w_handshake;
  logic [31:0]        w_dst_ext;

  // Shift register contents after one right shift; zero enters at the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign w_shift_next[gi] = 1'b0;
      end else begin : g_mid
        assign w_shift_next[gi] = r_shreg[gi+1];
      end
    end
  endgenerate

  assign w_handshake = r_sout_valid & sout_ready;
  assign w_dst_ext   = 32'(dst);

  // Sequencer: settle countdown, capture, and bit-by-bit handshaked shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_settle_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_sout        <= 1'b0;
      r_sout_valid  <= 1'b0;
      r_sout_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_signature   <= '0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
            r_busy       <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            // Capture edge: latch the result, fold it into the signature and
            // present bit 0 immediately.
            r_state      <= ST_SHIFT;
            r_shreg      <= dst;
            r_signature  <= r_signature + w_dst_ext;
            r_bit_cnt    <= BIT_LOAD;
            r_sout       <= dst[0];
            r_sout_valid <= 1'b1;
            r_sout_last  <= (BIT_LOAD == '0);
          end else begin
            r_settle_cnt <= r_settle_cnt - CNT_ONE;
          end
        end

        ST_SHIFT: begin
          // Without a handshake everything holds, which keeps the stream
          // stable under backpressure.
          if (w_handshake) begin
            if (r_bit_cnt == '0) begin
              r_state       <= ST_IDLE;
              r_sout        <= 1'b0;
              r_sout_valid  <= 1'b0;
              r_sout_last   <= 1'b0;
              r_busy        <= 1'b0;
              r_frame_count <= r_frame_count + 16'd1;
            end else begin
              r_shreg     <= w_shift_next;
              r_sout      <= w_shift_next[0];
              r_bit_cnt   <= r_bit_cnt - CNT_ONE;
              r_sout_last <= (r_bit_cnt == CNT_ONE);
            end
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_sout_last  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign sout        = r_sout;
  assign sout_valid  = r_sout_valid;
  assign sout_last   = r_sout_last;
  assign busy        = r_busy;
  assign signature   = r_signature;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_dst_serializer.sv
// Bench for dst_serializer: expected bits go into a scoreboard queue when a
// frame is started; a negedge monitor pops and compares on every handshake.
module tb_dst_serializer;
  localparam int WIDTH = 21;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] dst = '0;
  logic             start = 1'b0;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready = 1'b1;
  logic             sout_last;
  logic             busy;
  logic [31:0]      signature;
  logic [15:0]      frame_count;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         hs_count = 0;
  int         bp_mode = 0;
  int         bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;
  logic       stall_prev = 1'b0;
  logic [2:0] stall_val = '0;

  dst_serializer #(.WIDTH(WIDTH), .SETTLE(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .dst(dst), .start(start),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
    .sout_last(sout_last), .busy(busy), .signature(signature),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Consumer ready: always high, or the 1,0,0,1 pattern under backpressure.
  always @(posedge clk) begin
    #1;
    if (bp_mode != 0) begin
      sout_ready = bp_pat[bp_idx % 4];
      bp_idx++;
    end else begin
      sout_ready = 1'b1;
    end
  end

  // Monitor: compare each handshaked bit against the scoreboard and verify
  // outputs hold while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        check("stall_hold", 64'({sout_valid, sout, sout_last}), 64'(stall_val));
      if (sout_valid && sout_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_bit: got sout=%0d with no expected bit", sout);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check($sformatf("bit%0d", hs_count), 64'({sout, sout_last}), 64'({e.b, e.last}));
          $display("bit %0d: sout=%0d last=%0d", hs_count, sout, sout_last);
        end
        hs_count++;
      end
      stall_prev = sout_valid && !sout_ready;
      stall_val  = {sout_valid, sout, sout_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) begin
      exp_t e;
      e.b    = v[i];
      e.last = (i == WIDTH - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!sout_valid && n < 100) begin
      tick();
      n++;
    end
    if (!sout_valid) begin
      total++;
      bad++;
      $display("FAIL %s: sout_valid never rose within 100 cycles", name);
    end
  endtask

  task automatic end_frame(input string name, input logic [31:0] exp_sig,
                           input logic [15:0] exp_fc, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", name, budget);
    end
    check({name, "_left"}, 64'(sb_q.size()), 64'd0);
    check({name, "_valid"}, 64'(sout_valid), 64'd0);
    check({name, "_sig"}, 64'(signature), 64'(exp_sig));
    check({name, "_fc"}, 64'(frame_count), 64'(exp_fc));
    $display("%s: signature=0x%08h frame_count=%0d", name, signature, frame_count);
    sb_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    // Reset, then 50 idle cycles.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("idle", 64'({busy, sout_valid, sout, sout_last, signature, frame_count}), 64'd0);
      tick();
    end
    $display("idle: 50 cycles checked");

    // Frame 1: capture latency and bit order.
    dst = 21'h1A5A5A;
    push_frame(dst);
    pulse_start();
    check("busy_rise", 64'(busy), 64'd1);
    n = 0;
    while (!sout_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd17);
    check("sig_at_capture", 64'(signature), 64'h1A5A5A);
    end_frame("frame1", 32'h001A5A5A, 16'd1, 200);

    // Frame 2: starts during SETTLE, during SHIFT and on the final handshake.
    dst = 21'h1FFFFF;
    push_frame(dst);
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_valid("frame2_valid");
    tick();
    pulse_start();
    n = 0;
    while (!sout_last && n < 100) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    end_frame("frame2", 32'h003A5A59, 16'd2, 200);
    for (int i = 0; i < 25; i++) begin
      check("no_queued_start", 64'({busy, sout_valid}), 64'd0);
      tick();
    end

    // Frame 3: backpressure, and dst changes after capture.
    bp_mode = 1;
    dst = 21'h0F0F0F;
    push_frame(dst);
    pulse_start();
    wait_valid("frame3_valid");
    dst = 21'h1FFF00;
    end_frame("frame3", 32'h00496968, 16'd3, 400);
    bp_mode = 0;
    tick();

    // Frame 4: plain single-bit value.
    dst = 21'h000001;
    push_frame(dst);
    pulse_start();
    end_frame("frame4", 32'h00496969, 16'd4, 200);

    // Frame 5: reset after the tenth handshake aborts the frame.
    dst = 21'h155555;
    push_frame(dst);
    base = hs_count;
    pulse_start();
    n = 0;
    while ((hs_count - base) < 10 && n < 200) begin
      tick();
      n++;
    end
    check("reset_point", 64'(hs_count - base), 64'd10);
    rst_n = 1'b0;
    tick();
    check("reset_outs", 64'({sout, sout_valid, sout_last, busy}), 64'd0);
    check("reset_sig", 64'(signature), 64'd0);
    check("reset_fc", 64'(frame_count), 64'd0);
    $display("reset: outputs cleared, signature=0x%08h frame_count=%0d", signature, frame_count);
    rst_n = 1'b1;
    sb_q.delete();
    tick();

    // Frame 6: full frame after the abort.
    dst = 21'h0ABCDE;
    push_frame(dst);
    pulse_start();
    end_frame("frame6", 32'h000ABCDE, 16'd1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
